// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands an LM/SM instruction held in ID into one
// micro-op per selected register, lowest register first. Outputs are
// combinational from the current state and the ID-stage inputs.
// Optional feature: define LMSM_STALL_CNT_EN to build a saturating
// counter of cycles in which stall_up is asserted; otherwise stall_cnt is 0.
module lmsm_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        is_lm_in,
   input  logic        is_sm_in,
   input  logic [7:0]  reg_list,
   input  logic        pipe_stall,
   input  logic        flush,
   output logic        uop_valid,
   output logic        uop_is_lm,
   output logic        uop_is_sm,
   output logic [2:0]  reg_addr,
   output logic [15:0] addr_offset,
   output logic        last_uop,
   output logic        stall_up,
   output logic [15:0] stall_cnt
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t     state_reg, state_next;
   logic [7:0] rem_mask_reg, rem_mask_next;
   logic [2:0] cnt_reg, cnt_next;
   logic       op_lm_reg, op_lm_next;

   logic [7:0] active_mask;
   logic [7:0] sel_bit;
   logic [7:0] remaining;
   logic       start;
   logic       advance;
   logic       single_bit;
   logic [2:0] low_idx;

   // Decode the working mask, the start condition and the lowest selected register
   always_comb begin
      active_mask = (state_reg == IDLE) ? reg_list : rem_mask_reg;
      start       = !rst && (state_reg == IDLE) && valid_in &&
                    (is_lm_in || is_sm_in) && (reg_list != 8'd0);
      uop_valid   = start || (!rst && (state_reg == RUN));
      // Isolate the lowest set bit; what is left is the work after this micro-op
      sel_bit     = active_mask & (~active_mask + 8'd1);
      remaining   = active_mask & ~sel_bit;
      single_bit  = (active_mask != 8'd0) && (remaining == 8'd0);
      low_idx     = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (active_mask[i]) low_idx = 3'(i);
      end
      advance     = uop_valid && !pipe_stall;
   end

   // Micro-op outputs; LM takes priority when both opcode flags are set
   always_comb begin
      reg_addr    = uop_valid ? low_idx : 3'd0;
      addr_offset = rst ? 16'd0 : {13'd0, cnt_reg};
      last_uop    = uop_valid && single_bit;
      stall_up    = uop_valid && !single_bit;
      if (state_reg == IDLE) begin
         uop_is_lm = uop_valid && is_lm_in;
         uop_is_sm = uop_valid && is_sm_in && !is_lm_in;
      end else begin
         uop_is_lm = uop_valid && op_lm_reg;
         uop_is_sm = uop_valid && !op_lm_reg;
      end
   end

   // Next-state: flush squashes the sequence even while the pipe is stalled
   always_comb begin
      state_next    = state_reg;
      rem_mask_next = rem_mask_reg;
      cnt_next      = cnt_reg;
      op_lm_next    = op_lm_reg;
      if (flush) begin
         state_next    = IDLE;
         rem_mask_next = 8'd0;
         cnt_next      = 3'd0;
      end else if (advance) begin
         rem_mask_next = remaining;
         if (start) op_lm_next = is_lm_in;
         if (remaining != 8'd0) begin
            state_next = RUN;
            cnt_next   = cnt_reg + 3'd1;
         end else begin
            state_next = IDLE;
            cnt_next   = 3'd0;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         rem_mask_reg <= 8'd0;
         cnt_reg      <= 3'd0;
         op_lm_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         rem_mask_reg <= rem_mask_next;
         cnt_reg      <= cnt_next;
         op_lm_reg    <= op_lm_next;
      end
   end

`ifdef LMSM_STALL_CNT_EN
   logic [15:0] stall_cnt_reg;

   // Saturating count of cycles spent holding the front end
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_reg <= 16'd0;
      end else if (stall_up && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign stall_cnt = rst ? 16'd0 : stall_cnt_reg;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: table-driven IDLE-decode vectors, directed multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_lmsm_sequencer;

   logic        clk = 1'b0;
   logic        rst, valid_in, is_lm_in, is_sm_in, pipe_stall, flush;
   logic [7:0]  reg_list;
   logic        uop_valid, uop_is_lm, uop_is_sm, last_uop, stall_up;
   logic [2:0]  reg_addr;
   logic [15:0] addr_offset, stall_cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lmsm_sequencer dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .is_lm_in(is_lm_in),
      .is_sm_in(is_sm_in), .reg_list(reg_list), .pipe_stall(pipe_stall),
      .flush(flush), .uop_valid(uop_valid), .uop_is_lm(uop_is_lm),
      .uop_is_sm(uop_is_sm), .reg_addr(reg_addr), .addr_offset(addr_offset),
      .last_uop(last_uop), .stall_up(stall_up), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic       v, lm, sm;
      logic [7:0] list;
      logic       uv, olm, osm;
      logic [2:0] addr;
      logic       last, su;
   } vec_t;

   vec_t vecs[8];

   // Reference model state
   int q[$];
   int cur[$];
   int m_idx;
   bit m_lm;
   int m_scnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic lm, input logic sm, input logic [7:0] list,
                        input logic stall, input logic fl);
      valid_in = v; is_lm_in = lm; is_sm_in = sm; reg_list = list;
      pipe_stall = stall; flush = fl;
   endtask

   task automatic expect_all(input string tag, input logic uv, input logic lm, input logic sm,
                             input logic [2:0] a, input logic [15:0] off,
                             input logic last, input logic su);
      #1;
      chk({tag, ".uop_valid"}, {31'd0, uop_valid}, {31'd0, uv});
      chk({tag, ".uop_is_lm"}, {31'd0, uop_is_lm}, {31'd0, lm});
      chk({tag, ".uop_is_sm"}, {31'd0, uop_is_sm}, {31'd0, sm});
      chk({tag, ".reg_addr"}, {29'd0, reg_addr}, {29'd0, a});
      chk({tag, ".addr_offset"}, {16'd0, addr_offset}, {16'd0, off});
      chk({tag, ".last_uop"}, {31'd0, last_uop}, {31'd0, last});
      chk({tag, ".stall_up"}, {31'd0, stall_up}, {31'd0, su});
      $display("txn %s: uv=%0b lm=%0b sm=%0b addr=%0d off=%0d last=%0b su=%0b",
               tag, uop_valid, uop_is_lm, uop_is_sm, reg_addr, addr_offset, last_uop, stall_up);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step();
      rst = 1'b0;
   endtask

   initial begin
      int exp_sc;
      bit c_lm;
      int off;
      logic e_uv, e_lm, e_sm, e_last, e_su;
      logic [2:0] e_addr;

      vecs[0] = '{1'b1, 1'b1, 1'b0, 8'h25, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 8'h18, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1};

      // Reset behaviour: outputs forced low during rst, idle afterwards
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
      step();
      expect_all("in_reset", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      chk("in_reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      expect_all("after_reset", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      chk("after_reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);

      // First-micro-op decode table; pipe_stall keeps the sequencer in IDLE
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].v, vecs[i].lm, vecs[i].sm, vecs[i].list, 1'b1, 1'b0);
         expect_all($sformatf("vec%0d", i), vecs[i].uv, vecs[i].olm, vecs[i].osm,
                    vecs[i].addr, 16'd0, vecs[i].last, vecs[i].su);
         step();
      end
      do_reset();

      // LM 0010_0101, no stalls
      drive(1'b1, 1'b1, 1'b0, 8'h25, 1'b0, 1'b0);
      expect_all("lm25.u0", 1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b1); step();
      expect_all("lm25.u1", 1'b1, 1'b1, 1'b0, 3'd2, 16'd1, 1'b0, 1'b1); step();
      expect_all("lm25.u2", 1'b1, 1'b1, 1'b0, 3'd5, 16'd2, 1'b1, 1'b0); step();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      expect_all("lm25.done", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      // SM 0x80 held by pipe_stall for two cycles
      drive(1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
      expect_all("sm80.h0", 1'b1, 1'b0, 1'b1, 3'd7, 16'd0, 1'b1, 1'b0); step();
      expect_all("sm80.h1", 1'b1, 1'b0, 1'b1, 3'd7, 16'd0, 1'b1, 1'b0); step();
      pipe_stall = 1'b0;
      expect_all("sm80.go", 1'b1, 1'b0, 1'b1, 3'd7, 16'd0, 1'b1, 1'b0); step();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      expect_all("sm80.done", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);

      // LM 0xFF flushed on the fourth micro-op, then SM 0x02
      drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         expect_all($sformatf("lmff.u%0d", k), 1'b1, 1'b1, 1'b0, 3'(k), 16'(k), 1'b0, 1'b1);
         step();
      end
      flush = 1'b1;
      expect_all("lmff.u3", 1'b1, 1'b1, 1'b0, 3'd3, 16'd3, 1'b0, 1'b1); step();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      expect_all("lmff.flushed", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0);
      expect_all("sm02", 1'b1, 1'b0, 1'b1, 3'd1, 16'd0, 1'b1, 1'b0); step();

      // LM 0xF0 with reset on the second micro-op
      drive(1'b1, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
      expect_all("lmf0.u0", 1'b1, 1'b1, 1'b0, 3'd4, 16'd0, 1'b0, 1'b1); step();
      rst = 1'b1;
      flush = 1'b1;
      expect_all("lmf0.rst", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0); step();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      expect_all("lmf0.idle", 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
      expect_all("lm01", 1'b1, 1'b1, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0); step();

      // Stall-cycle counter over a full LM 0xFF
      do_reset();
      drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) step();
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      #1;
`ifdef LMSM_STALL_CNT_EN
      exp_sc = 7;
`else
      exp_sc = 0;
`endif
      chk("lmff.stall_cnt", {16'd0, stall_cnt}, exp_sc);
      $display("txn stall_cnt: value=%0d", stall_cnt);

      // Randomized traffic against the reference model
      do_reset();
      q.delete(); m_idx = 0; m_lm = 1'b0; m_scnt = 0;
      for (int n = 0; n < 3000; n++) begin
         int kind;
         rst        = ($urandom_range(0, 59) == 0);
         flush      = ($urandom_range(0, 19) == 0);
         pipe_stall = ($urandom_range(0, 3) == 0);
         valid_in   = ($urandom_range(0, 3) != 0);
         kind       = $urandom_range(0, 3);
         is_lm_in   = (kind == 0) || (kind == 2);
         is_sm_in   = (kind == 1) || (kind == 2);
         reg_list   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         #1;

         // Expected micro-op list: pending work, or a freshly decoded instruction
         cur.delete();
         c_lm = 1'b0;
         off  = 0;
         if (q.size() > 0) begin
            cur  = q;
            c_lm = m_lm;
            off  = m_idx;
         end else if (valid_in && (is_lm_in || is_sm_in)) begin
            for (int b = 0; b < 8; b++) if (reg_list[b]) cur.push_back(b);
            c_lm = is_lm_in;
         end
         if (rst) begin
            cur.delete();
            off = 0;
         end
         e_uv   = (cur.size() > 0);
         e_lm   = e_uv && c_lm;
         e_sm   = e_uv && !c_lm;
         e_addr = e_uv ? 3'(cur[0]) : 3'd0;
         e_last = (cur.size() == 1);
         e_su   = (cur.size() > 1);
         chk("rnd.uop_valid", {31'd0, uop_valid}, {31'd0, e_uv});
         chk("rnd.uop_is_lm", {31'd0, uop_is_lm}, {31'd0, e_lm});
         chk("rnd.uop_is_sm", {31'd0, uop_is_sm}, {31'd0, e_sm});
         chk("rnd.reg_addr", {29'd0, reg_addr}, {29'd0, e_addr});
         chk("rnd.addr_offset", {16'd0, addr_offset}, off);
         chk("rnd.last_uop", {31'd0, last_uop}, {31'd0, e_last});
         chk("rnd.stall_up", {31'd0, stall_up}, {31'd0, e_su});
`ifdef LMSM_STALL_CNT_EN
         chk("rnd.stall_cnt", {16'd0, stall_cnt}, rst ? 0 : m_scnt);
`else
         chk("rnd.stall_cnt", {16'd0, stall_cnt}, 0);
`endif

         // Model update for the coming edge
         if (rst) begin
            q.delete(); m_idx = 0; m_scnt = 0;
         end else begin
            if (e_su && m_scnt < 65535) m_scnt++;
            if (flush) begin
               q.delete(); m_idx = 0;
            end else if (e_uv && !pipe_stall) begin
               void'(cur.pop_front());
               q     = cur;
               m_lm  = c_lm;
               m_idx = (q.size() > 0) ? off + 1 : 0;
            end
         end
         step();
      end
      $display("txn random: cycles=3000");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
